cart_bus_ctrl: RTL and testbench

Sequences Game Boy cartridge bus cycles for the FPGA header interface, shared between two requesters through a round-robin arbiter. Port 0 is the host/debug path and port 1 is the ROM-dump engine. The block drives address, strobes, chip-select and write data with programmable setup/access/hold timing. It samples read data and returns it to the granted requester with a one-cycle ack.

---
 rtl/cart_pkg.sv | 30 +++
 rtl/cart_rr_arb.sv | 44 ++++
 rtl/cart_bus_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cart_bus_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cart_pkg
//  Brief    : Shared types and constants for the cartridge bus controller:
//             FSM state encoding, SRAM window bounds, port count and counter
//             width, plus the SRAM address decode helper.
//  Revision : 1.0  initial release
// ============================================================================
package cart_pkg;

  localparam int N_PORTS = 2;
  localparam int CNT_W   = 8;

  localparam logic [15:0] SRAM_BASE = 16'hA000;
  localparam logic [15:0] SRAM_LAST = 16'hBFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  // True when the address falls in the cartridge external-RAM window.
  function automatic logic is_sram(input logic [15:0] addr);
    return (addr >= SRAM_BASE) && (addr <= SRAM_LAST);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cart_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cart_rr_arb
//  Brief    : Two-port round-robin arbiter. Purely combinational grant; the
//             only state is the last-grant pointer, which moves only when a
//             grant is actually taken. Pointer resets to port 1 so port 0
//             wins the first contention.
//  Revision : 1.0  initial release
// ============================================================================
module cart_rr_arb
  import cart_pkg::*;
(
  input  logic               clock,
  input  logic               reset_l,
  input  logic [N_PORTS-1:0] req,
  input  logic               grant_en,
  output logic               grant_valid,
  output logic               grant_idx
);

  logic r_last;

  // Grant the requesting port; on contention favour the one not served last.
  always_comb begin
    grant_valid = |req;
    grant_idx   = 1'b0;
    if (req == 2'b11) begin
      grant_idx = ~r_last;
    end else begin
      grant_idx = req[1];
    end
  end

  // Remember who was served, but only when the grant is consumed.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_last <= 1'b1;
    end else if (grant_en && grant_valid) begin
      r_last <= grant_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cart_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cart_bus_ctrl
//  Brief    : Game Boy cartridge bus cycle sequencer shared by two requesters
//             (port 0 host/debug, port 1 ROM dump) through a round-robin
//             arbiter. IDLE -> SETUP -> STROBE -> HOLD with programmable
//             cycle counts; every cartridge-facing output is registered.
//             Macro CART_WRITE_EN enables write cycles; without it every
//             request runs as a read and the write-side outputs stay idle.
//  Revision : 1.0  initial release
// ============================================================================
module cart_bus_ctrl
  import cart_pkg::*;
#(
  parameter int SETUP_CYC  = 2,
  parameter int ACCESS_CYC = 8,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clock,
  input  logic        reset_l,
  input  logic [1:0]  req,
  input  logic [1:0]  req_we,
  input  logic [31:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic [1:0]  ack,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [15:0] cart_addr,
  input  logic [7:0]  cart_data_in,
  output logic [7:0]  cart_data_out,
  output logic        cart_data_oe,
  output logic        cart_rd_l,
  output logic        cart_wr_l,
  output logic        cart_cs_sram_l,
  output logic        cart_reset_l
);

  // Counter reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [CNT_W-1:0] c_setup_ld  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] c_access_ld = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] c_hold_ld   = CNT_W'(HOLD_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic        w_start;
  logic        w_strobe_go;
  logic        w_strobe_end;
  logic        w_hold_end;

  logic        w_gnt_valid;
  logic        w_gnt_idx;
  logic [15:0] w_sel_addr;
  logic        w_sel_we;
  logic [7:0]  w_sel_wdata;

  logic        r_gnt;
  logic        r_we;

  cart_rr_arb u_arb (
    .clock       (clock),
    .reset_l     (reset_l),
    .req         (req),
    .grant_en    (r_state == IDLE),
    .grant_valid (w_gnt_valid),
    .grant_idx   (w_gnt_idx)
  );

  assign w_sel_addr = w_gnt_idx ? req_addr[31:16] : req_addr[15:0];

`ifdef CART_WRITE_EN
  assign w_sel_we    = req_we[w_gnt_idx];
  assign w_sel_wdata = w_gnt_idx ? req_wdata[15:8] : req_wdata[7:0];
`else
  // Read-only build: write request fields are deliberately unused.
  logic w_unused_wr;
  assign w_unused_wr = ^{req_we, req_wdata};
  assign w_sel_we    = 1'b0;
  assign w_sel_wdata = 8'h00;
`endif

  // State and phase counter register.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter reload on every phase entry, and phase-edge events.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_start      = 1'b0;
    w_strobe_go  = 1'b0;
    w_strobe_end = 1'b0;
    w_hold_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_start     = 1'b1;
          w_state_nxt = SETUP;
          w_cnt_nxt   = c_setup_ld;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_strobe_go = 1'b1;
          w_state_nxt = STROBE;
          w_cnt_nxt   = c_access_ld;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      STROBE: begin
        if (r_cnt == '0) begin
          w_strobe_end = 1'b1;
          w_state_nxt  = HOLD;
          w_cnt_nxt    = c_hold_ld;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_hold_end  = 1'b1;
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Registered bus outputs, updated only on phase edges so strobes never glitch.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      r_gnt          <= 1'b0;
      r_we           <= 1'b0;
      ack            <= '0;
      rdata          <= '0;
      busy           <= 1'b0;
      cart_addr      <= '0;
      cart_data_out  <= '0;
      cart_data_oe   <= 1'b0;
      cart_rd_l      <= 1'b1;
      cart_wr_l      <= 1'b1;
      cart_cs_sram_l <= 1'b1;
      cart_reset_l   <= 1'b0;
    end else begin
      cart_reset_l <= 1'b1;
      ack          <= '0;
      busy         <= (w_state_nxt != IDLE);
      if (w_start) begin
        r_gnt          <= w_gnt_idx;
        r_we           <= w_sel_we;
        cart_addr      <= w_sel_addr;
        cart_cs_sram_l <= ~is_sram(w_sel_addr);
        cart_data_oe   <= w_sel_we;
        if (w_sel_we) begin
          cart_data_out <= w_sel_wdata;
        end
      end
      if (w_strobe_go) begin
        cart_rd_l <= r_we;
        cart_wr_l <= ~r_we;
      end
      if (w_strobe_end) begin
        cart_rd_l <= 1'b1;
        cart_wr_l <= 1'b1;
        ack       <= r_gnt ? 2'b10 : 2'b01;
        if (!r_we) begin
          rdata <= cart_data_in;
        end
      end
      if (w_hold_end) begin
        cart_cs_sram_l <= 1'b1;
        cart_data_oe   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cart_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cart_bus_ctrl
//  Brief    : Directed self-checking bench for cart_bus_ctrl with default
//             timing (2/8/1). Expected values are hand-derived; write-cycle
//             expectations follow CART_WRITE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cart_bus_ctrl;

`ifdef CART_WRITE_EN
  localparam bit c_wr_en = 1'b1;
`else
  localparam bit c_wr_en = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_l;
  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [31:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [15:0] cart_addr;
  logic [7:0]  cart_data_in;
  logic [7:0]  cart_data_out;
  logic        cart_data_oe;
  logic        cart_rd_l;
  logic        cart_wr_l;
  logic        cart_cs_sram_l;
  logic        cart_reset_l;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  cart_bus_ctrl dut (
    .clock          (clock),
    .reset_l        (reset_l),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .ack            (ack),
    .rdata          (rdata),
    .busy           (busy),
    .cart_addr      (cart_addr),
    .cart_data_in   (cart_data_in),
    .cart_data_out  (cart_data_out),
    .cart_data_oe   (cart_data_oe),
    .cart_rd_l      (cart_rd_l),
    .cart_wr_l      (cart_wr_l),
    .cart_cs_sram_l (cart_cs_sram_l),
    .cart_reset_l   (cart_reset_l)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One request on port p starting in the current (IDLE) cycle; k counts
  // cycles after the grant cycle. req drops at ack, or at cycle drop_k.
  task automatic run_single(input int p, input logic we, input logic [15:0] addr,
                            input logic [7:0] wd, input int drop_k,
                            output int ack_k, output logic [1:0] ack_v, output int n_ack,
                            output int rd_n, output int wr_n, output int cs_n,
                            output int oe_n, output int busy_n, output logic [7:0] dout);
    ack_k = -1; ack_v = 2'b00; n_ack = 0; rd_n = 0; wr_n = 0;
    cs_n = 0; oe_n = 0; busy_n = 0; dout = 8'h00;
    req_addr[p*16 +: 16] = addr;
    req_wdata[p*8 +: 8]  = wd;
    req_we[p]            = we;
    req[p]               = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (!cart_rd_l)      rd_n++;
      if (!cart_wr_l)      wr_n++;
      if (!cart_cs_sram_l) cs_n++;
      if (busy)            busy_n++;
      if (cart_data_oe) begin
        oe_n++;
        dout = cart_data_out;
      end
      if (ack != 2'b00) begin
        n_ack++;
        if (ack_k < 0) begin
          ack_k = k;
          ack_v = ack;
        end
      end
      if (k == drop_k || ack != 2'b00) req[p] = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ack_k, n_ack, rd_n, wr_n, cs_n, oe_n, busy_n, n;
    logic [1:0]  ack_v;
    logic [7:0]  dout;
    int          ack_t [4];
    logic [1:0]  ack_s [4];

    reset_l = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    cart_data_in = 8'h00;
    repeat (3) step();

    // Reset values
    check_val("rst_rd_l",     cart_rd_l,      1);
    check_val("rst_wr_l",     cart_wr_l,      1);
    check_val("rst_cs_l",     cart_cs_sram_l, 1);
    check_val("rst_oe",       cart_data_oe,   0);
    check_val("rst_dout",     cart_data_out,  0);
    check_val("rst_addr",     cart_addr,      0);
    check_val("rst_rdata",    rdata,          0);
    check_val("rst_ack",      ack,            0);
    check_val("rst_busy",     busy,           0);
    check_val("rst_cart_rst", cart_reset_l,   0);
    reset_l = 1'b1;
    #1;
    check_val("rel_cart_rst_low", cart_reset_l, 0);
    step();
    check_val("rel_cart_rst_high", cart_reset_l, 1);

    // Port-0 read of 0x0134
    cart_data_in = 8'h4E;
    run_single(0, 1'b0, 16'h0134, 8'h00, 0, ack_k, ack_v, n_ack, rd_n, wr_n, cs_n, oe_n, busy_n, dout);
    check_val("rd_ack_cycle", ack_k,  11);
    check_val("rd_ack_val",   ack_v,  2'b01);
    check_val("rd_ack_count", n_ack,  1);
    check_val("rd_rd_low",    rd_n,   8);
    check_val("rd_wr_low",    wr_n,   0);
    check_val("rd_cs_low",    cs_n,   0);
    check_val("rd_busy",      busy_n, 11);
    check_val("rd_rdata",     rdata,  8'h4E);
    check_val("rd_addr",      cart_addr, 16'h0134);

    // Port-1 write of 0xA5 to 0xA010 (becomes a read in the read-only build)
    cart_data_in = 8'h77;
    run_single(1, 1'b1, 16'hA010, 8'hA5, 0, ack_k, ack_v, n_ack, rd_n, wr_n, cs_n, oe_n, busy_n, dout);
    check_val("wr_ack_cycle", ack_k, 11);
    check_val("wr_ack_val",   ack_v, 2'b10);
    check_val("wr_cs_low",    cs_n,  11);
    check_val("wr_oe_high",   oe_n,  c_wr_en ? 11 : 0);
    check_val("wr_wr_low",    wr_n,  c_wr_en ? 8 : 0);
    check_val("wr_rd_low",    rd_n,  c_wr_en ? 0 : 8);
    check_val("wr_dout_seen", dout,  c_wr_en ? 8'hA5 : 8'h00);
    check_val("wr_dout_end",  cart_data_out, c_wr_en ? 8'hA5 : 8'h00);
    check_val("wr_rdata",     rdata, c_wr_en ? 8'h4E : 8'h77);
    check_val("wr_idle_cs",   cart_cs_sram_l, 1);
    check_val("wr_idle_oe",   cart_data_oe,   0);

    // Asynchronous reset in the 4th STROBE cycle of an SRAM read
    cart_data_in = 8'h11;
    req_addr[15:0] = 16'hA100; req_we[0] = 1'b0; req[0] = 1'b1;
    repeat (6) step();
    check_val("abort_pre_rd_l", cart_rd_l,      0);
    check_val("abort_pre_cs_l", cart_cs_sram_l, 0);
    reset_l = 1'b0;
    req[0]  = 1'b0;
    #1;
    check_val("abort_rd_l",     cart_rd_l,      1);
    check_val("abort_wr_l",     cart_wr_l,      1);
    check_val("abort_cs_l",     cart_cs_sram_l, 1);
    check_val("abort_oe",       cart_data_oe,   0);
    check_val("abort_busy",     busy,           0);
    check_val("abort_addr",     cart_addr,      0);
    check_val("abort_rdata",    rdata,          0);
    check_val("abort_cart_rst", cart_reset_l,   0);
    repeat (3) begin
      step();
      check_val("abort_no_ack", ack, 0);
    end
    reset_l = 1'b1;
    #1;
    check_val("abort_rel_cart_rst_low", cart_reset_l, 0);
    step();
    check_val("abort_rel_cart_rst_high", cart_reset_l, 1);

    // Continuous contention: pointer resets to port 1, so port 0 goes first
    cart_data_in = 8'h5A;
    req_addr = {16'h0200, 16'h0100};
    req_we = 2'b00;
    req = 2'b11;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      ack_t[i] = -1;
      ack_s[i] = 2'b00;
    end
    for (int k = 1; k <= 52; k++) begin
      step();
      if (ack != 2'b00) begin
        if (n < 4) begin
          ack_t[n] = k;
          ack_s[n] = ack;
        end
        n++;
        if (n == 4) req = 2'b00;
      end
    end
    check_val("rr_ack_count", n, 4);
    check_val("rr_t0", ack_t[0], 11);
    check_val("rr_t1", ack_t[1], 23);
    check_val("rr_t2", ack_t[2], 35);
    check_val("rr_t3", ack_t[3], 47);
    check_val("rr_v0", ack_s[0], 2'b01);
    check_val("rr_v1", ack_s[1], 2'b10);
    check_val("rr_v2", ack_s[2], 2'b01);
    check_val("rr_v3", ack_s[3], 2'b10);
    check_val("rr_idle_busy", busy,  0);
    check_val("rr_rdata",     rdata, 8'h5A);
    check_val("rr_last_addr", cart_addr, 16'h0200);

    // req dropped during SETUP: cycle still completes, exactly once
    cart_data_in = 8'hC3;
    run_single(0, 1'b0, 16'h4000, 8'h00, 1, ack_k, ack_v, n_ack, rd_n, wr_n, cs_n, oe_n, busy_n, dout);
    check_val("drop_ack_cycle", ack_k,  11);
    check_val("drop_ack_val",   ack_v,  2'b01);
    check_val("drop_ack_count", n_ack,  1);
    check_val("drop_busy",      busy_n, 11);
    check_val("drop_rd_low",    rd_n,   8);
    check_val("drop_rdata",     rdata,  8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
